// File: rtl/mgmt_bus_interconnect_if.sv
// rtl/mgmt_bus_interconnect_if.sv - host and peripheral signal bundle of the management bus fabric
interface mgmt_bus_interconnect_if #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW_BITS = 12
);
    logic                            rd_en;
    logic [ADDR_WIDTH-1:0]           rd_addr;
    logic                            rd_valid;
    logic [DATA_WIDTH-1:0]           rd_data;
    logic                            rd_err;
    logic                            wr_en;
    logic [ADDR_WIDTH-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]           wr_data;
    logic                            wr_err;
    logic [NUM_PORTS-1:0]            p_rd_en;
    logic [WINDOW_BITS-1:0]          p_rd_addr;
    logic [NUM_PORTS-1:0]            p_rd_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] p_rd_data;
    logic [NUM_PORTS-1:0]            p_wr_en;
    logic [WINDOW_BITS-1:0]          p_wr_addr;
    logic [DATA_WIDTH-1:0]           p_wr_data;
    logic                            busy;
    logic [15:0]                     timeout_count;

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, p_rd_valid, p_rd_data,
        output rd_valid, rd_data, rd_err, wr_err, p_rd_en, p_rd_addr,
               p_wr_en, p_wr_addr, p_wr_data, busy, timeout_count
    );

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, p_rd_valid, p_rd_data,
        input  rd_valid, rd_data, rd_err, wr_err, p_rd_en, p_rd_addr,
               p_wr_en, p_wr_addr, p_wr_data, busy, timeout_count
    );
endinterface

// File: rtl/mgmt_bus_interconnect.sv
// rtl/mgmt_bus_interconnect.sv - window-decoded management bus fan-out with one outstanding read and timeout
module mgmt_bus_interconnect #(
    parameter int                   NUM_PORTS      = 4,
    parameter int                   ADDR_WIDTH     = 16,
    parameter int                   DATA_WIDTH     = 8,
    parameter int                   WINDOW_BITS    = 12,
    parameter int                   REQ_PIPE       = 1,
    parameter int                   RSP_PIPE       = 0,
    parameter int                   TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA      = DATA_WIDTH'(8'hEE)
) (
    input  logic clk,
    input  logic rst_n,
    mgmt_bus_interconnect_if.slave bus
);
    localparam int RW = 1 + ADDR_WIDTH;
    localparam int WW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {IDLE, WAIT} state_t;

    logic                  rd_q_en, wr_q_en;
    logic [ADDR_WIDTH-1:0] rd_q_addr, wr_q_addr;
    logic [DATA_WIDTH-1:0] wr_q_data;

    generate
        if (REQ_PIPE == 0) begin : g_req_comb
            assign {rd_q_en, rd_q_addr}            = {bus.rd_en, bus.rd_addr};
            assign {wr_q_en, wr_q_addr, wr_q_data} = {bus.wr_en, bus.wr_addr, bus.wr_data};
        end else begin : g_req_pipe
            logic [REQ_PIPE-1:0][RW-1:0] rd_sr;
            logic [REQ_PIPE-1:0][WW-1:0] wr_sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_sr <= '0;
                    wr_sr <= '0;
                end else begin
                    rd_sr[0] <= {bus.rd_en, bus.rd_addr};
                    wr_sr[0] <= {bus.wr_en, bus.wr_addr, bus.wr_data};
                    for (int i = 1; i < REQ_PIPE; i++) begin
                        rd_sr[i] <= rd_sr[i-1];
                        wr_sr[i] <= wr_sr[i-1];
                    end
                end
            end
            assign {rd_q_en, rd_q_addr}            = rd_sr[REQ_PIPE-1];
            assign {wr_q_en, wr_q_addr, wr_q_data} = wr_sr[REQ_PIPE-1];
        end
    endgenerate

    // Mapped only if the port index exists and nothing is set above the index nibble.
    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a[WINDOW_BITS +: 4]) < NUM_PORTS) && ((a >> (WINDOW_BITS + 4)) == '0);
    endfunction

    logic [3:0] rd_idx, wr_idx;
    logic       rd_map, wr_map;
    assign rd_idx = rd_q_addr[WINDOW_BITS +: 4];
    assign wr_idx = wr_q_addr[WINDOW_BITS +: 4];
    assign rd_map = is_mapped(rd_q_addr);
    assign wr_map = is_mapped(wr_q_addr);

    state_t          state;
    logic [3:0]      sel;
    logic [15:0]     timer;
    logic [15:0]     to_cnt;
    logic [15:0]     vld_pad;
    logic [DATA_WIDTH-1:0] sel_data;
    logic            sel_valid, timed_out, rd_go, rd_bad, wr_go;
    logic            rsp_valid, rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [NUM_PORTS-1:0]  rd_strobe, wr_strobe;

    assign vld_pad   = 16'(bus.p_rd_valid);
    assign sel_valid = (state == WAIT) && vld_pad[sel];
    assign timed_out = (state == WAIT) && !sel_valid && (timer == 16'(TIMEOUT_CYCLES - 1));
    assign rd_go     = (state == IDLE) && rd_q_en && rd_map;
    assign rd_bad    = (state == IDLE) && rd_q_en && !rd_map;
    assign wr_go     = wr_q_en && wr_map;
    assign rsp_valid = sel_valid || timed_out || rd_bad;
    assign rsp_err   = !sel_valid;
    assign rsp_data  = sel_valid ? sel_data : ERR_DATA;

    always_comb begin
        sel_data  = '0;
        rd_strobe = '0;
        wr_strobe = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (sel == 4'(k)) sel_data = bus.p_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
            rd_strobe[k] = rd_go && (rd_idx == 4'(k));
            wr_strobe[k] = wr_go && (wr_idx == 4'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            timer  <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (rd_go) begin
                    sel   <= rd_idx;
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: if (sel_valid) begin
                    state <= IDLE;
                end else if (timed_out) begin
                    state <= IDLE;
                    if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
                end else begin
                    timer <= timer + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p_rd_en       = rd_strobe;
    assign bus.p_rd_addr     = rd_q_addr[WINDOW_BITS-1:0];
    assign bus.p_wr_en       = wr_strobe;
    assign bus.p_wr_addr     = wr_q_addr[WINDOW_BITS-1:0];
    assign bus.p_wr_data     = wr_q_data;
    assign bus.wr_err        = wr_q_en && !wr_map;
    assign bus.busy          = (state == WAIT);
    assign bus.timeout_count = to_cnt;

    generate
        if (RSP_PIPE == 0) begin : g_rsp_comb
            logic [DATA_WIDTH-1:0] data_hold;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         data_hold <= '0;
                else if (rsp_valid) data_hold <= rsp_data;
            end
            assign bus.rd_valid = rsp_valid;
            assign bus.rd_err   = rsp_valid && rsp_err;
            assign bus.rd_data  = rsp_valid ? rsp_data : data_hold;
        end else begin : g_rsp_pipe
            logic                  v_q, e_q;
            logic [DATA_WIDTH-1:0] d_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    e_q <= 1'b0;
                    d_q <= '0;
                end else begin
                    v_q <= rsp_valid;
                    e_q <= rsp_valid && rsp_err;
                    if (rsp_valid) d_q <= rsp_data;
                end
            end
            assign bus.rd_valid = v_q;
            assign bus.rd_err   = e_q;
            assign bus.rd_data  = d_q;
        end
    endgenerate
endmodule

// File: tb/tb_mgmt_bus_interconnect.sv
// tb/tb_mgmt_bus_interconnect.sv - scoreboard bench for mgmt_bus_interconnect (REQ_PIPE=1, RSP_PIPE=0, timeout 8)
module tb_mgmt_bus_interconnect;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    mgmt_bus_interconnect_if #(.NUM_PORTS(NP), .ADDR_WIDTH(16), .DATA_WIDTH(8), .WINDOW_BITS(12)) bus();

    mgmt_bus_interconnect #(
        .NUM_PORTS(NP), .ADDR_WIDTH(16), .DATA_WIDTH(8), .WINDOW_BITS(12),
        .REQ_PIPE(1), .RSP_PIPE(0), .TIMEOUT_CYCLES(8), .ERR_DATA(8'hEE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [7:0] d, input logic e, input int c);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = c;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rd_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", 32'(bus.rd_data), 32'(e.data));
                check("rsp_err", 32'(bus.rd_err), 32'(e.err));
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.p_rd_valid = '0; bus.p_rd_data = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_wr_err", 32'(bus.wr_err), 0);
        check("rst_p_rd_en", 32'(bus.p_rd_en), 0);
        check("rst_p_wr_en", 32'(bus.p_wr_en), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_tocnt", 32'(bus.timeout_count), 0);
        step(); rst_n = 1;

        // mapped write, one cycle of request latency
        step(); bus.wr_en = 1; bus.wr_addr = 16'h1234; bus.wr_data = 8'h5A;
        @(negedge clk); check("wr_early", 32'(bus.p_wr_en), 0);
        step(); bus.wr_en = 0;
        @(negedge clk);
        check("wr_en", 32'(bus.p_wr_en), 32'b0010);
        check("wr_addr", 32'(bus.p_wr_addr), 32'h234);
        check("wr_data", 32'(bus.p_wr_data), 32'h5A);
        check("wr_err0", 32'(bus.wr_err), 0);
        step(); @(negedge clk); check("wr_pulse", 32'(bus.p_wr_en), 0);

        // read answered by port 2 three cycles after its strobe
        step(); bus.rd_en = 1; bus.rd_addr = 16'h2010; c0 = cyc;
        expect_rsp(8'hC3, 1'b0, c0 + 4);
        @(negedge clk); check("rd_early", 32'(bus.p_rd_en), 0);
        step(); bus.rd_en = 0;
        @(negedge clk);
        check("rd_strobe", 32'(bus.p_rd_en), 32'b0100);
        check("rd_off", 32'(bus.p_rd_addr), 32'h010);
        step(); @(negedge clk);
        check("rd_busy", 32'(bus.busy), 1);
        check("rd_pulse", 32'(bus.p_rd_en), 0);
        step();
        step(); bus.p_rd_valid = 4'b0100; bus.p_rd_data[2*8 +: 8] = 8'hC3;
        step(); bus.p_rd_valid = '0;
        @(negedge clk); check("rd_idle", 32'(bus.busy), 0);

        // silent port 3 times out 8 cycles after its strobe
        step(); bus.rd_en = 1; bus.rd_addr = 16'h3000; c0 = cyc;
        expect_rsp(8'hEE, 1'b1, c0 + 9);
        step(); bus.rd_en = 0;
        @(negedge clk); check("to_strobe", 32'(bus.p_rd_en), 32'b1000);
        repeat (9) step();
        @(negedge clk);
        check("to_busy", 32'(bus.busy), 0);
        check("to_cnt1", 32'(bus.timeout_count), 1);

        // unmapped read and write
        step(); bus.rd_en = 1; bus.rd_addr = 16'h5000; c0 = cyc;
        expect_rsp(8'hEE, 1'b1, c0 + 1);
        step(); bus.rd_en = 0;
        @(negedge clk);
        check("um_no_strobe", 32'(bus.p_rd_en), 0);
        check("um_not_busy", 32'(bus.busy), 0);
        step(); bus.wr_en = 1; bus.wr_addr = 16'h5000; bus.wr_data = 8'h11;
        step(); bus.wr_en = 0;
        @(negedge clk);
        check("um_wr_err", 32'(bus.wr_err), 1);
        check("um_no_wr", 32'(bus.p_wr_en), 0);

        // during WAIT: dropped read, stray valid, forwarded write
        step(); bus.rd_en = 1; bus.rd_addr = 16'h1004; c0 = cyc;
        step(); bus.rd_en = 0;
        @(negedge clk); check("w_strobe", 32'(bus.p_rd_en), 32'b0010);
        step(); bus.rd_en = 1; bus.rd_addr = 16'h0008; bus.wr_en = 1; bus.wr_addr = 16'h0020; bus.wr_data = 8'h77;
        bus.p_rd_valid = 4'b0001; bus.p_rd_data[0 +: 8] = 8'h99;
        step(); bus.rd_en = 0; bus.wr_en = 0; bus.p_rd_valid = '0;
        @(negedge clk);
        check("w_drop_rd", 32'(bus.p_rd_en), 0);
        check("w_fwd_wr", 32'(bus.p_wr_en), 32'b0001);
        check("w_fwd_data", 32'(bus.p_wr_data), 32'h77);
        check("w_still_busy", 32'(bus.busy), 1);
        step(); bus.p_rd_valid = 4'b0010; bus.p_rd_data[1*8 +: 8] = 8'hA7;
        expect_rsp(8'hA7, 1'b0, c0 + 4);
        step(); bus.p_rd_valid = '0;
        @(negedge clk); check("w_idle", 32'(bus.busy), 0);

        // reset during WAIT aborts the read
        step(); bus.rd_en = 1; bus.rd_addr = 16'h2000;
        step(); bus.rd_en = 0;
        step(); rst_n = 0;
        @(negedge clk);
        check("ra_busy", 32'(bus.busy), 0);
        check("ra_tocnt", 32'(bus.timeout_count), 0);
        step(); rst_n = 1;
        step(); bus.p_rd_valid = 4'b0100; bus.p_rd_data[2*8 +: 8] = 8'h44;
        @(negedge clk); check("ra_late_busy", 32'(bus.busy), 0);
        step(); bus.p_rd_valid = '0;

        // valid on the timeout cycle wins
        step(); bus.rd_en = 1; bus.rd_addr = 16'h3000; c0 = cyc;
        step(); bus.rd_en = 0;
        repeat (8) step();
        bus.p_rd_valid = 4'b1000; bus.p_rd_data[3*8 +: 8] = 8'h3C;
        expect_rsp(8'h3C, 1'b0, c0 + 9);
        @(negedge clk); check("tv_cnt_same", 32'(bus.timeout_count), 0);
        step(); bus.p_rd_valid = '0;
        @(negedge clk);
        check("tv_cnt", 32'(bus.timeout_count), 0);
        check("tv_busy", 32'(bus.busy), 0);
        check("tv_hold", 32'(bus.rd_data), 32'h3C);

        repeat (3) step();
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
